// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: reset defaults,
// FSM state encoding and the byte-to-word address helper.
package imem_fetch_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam int          DEF_MEM_WORDS  = 256;
    localparam int          DEF_STARVE_MAX = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Instruction memory is word addressed: drop the byte offset.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return 30'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle around the fetch controller: instruction-memory read port,
// decode-side valid/ready stream and the debug/loader read requester.
interface imem_fetch_ctrl_if;

    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    // Fetch controller side.
    modport master (
        output mem_req, mem_addr,
        input  mem_rdata,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata
    );

    // Memory / decode / debug environment side.
    modport slave (
        input  mem_req, mem_addr,
        output mem_rdata,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_queue2.sv
// Two-entry FIFO between the memory response and decode. Flush wins over a
// same-cycle push; push into a full queue is accepted only with a pop.
module imem_fetch_ctrl_fetch_queue2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot_p0 [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    // Accept pop only with data present; push into full only alongside a pop.
    always_comb begin
        do_pop  = pop && (cnt != 2'd0);
        do_push = push && ((cnt != 2'd2) || do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Slot storage carries no reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) slot_p0[wr_ptr] <= push_data;
    end

    assign head_valid = (cnt != 2'd0);
    assign head_data  = slot_p0[rd_ptr];
    assign count      = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues word reads, buffers
// responses for decode, applies redirects and shares the read port with a
// debug requester that is guaranteed a grant after a bounded wait.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int          MEM_WORDS  = DEF_MEM_WORDS,
    parameter int          STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    halt_req,
    imem_fetch_ctrl_if.master       bus,
    output logic                    fault,
    output logic [31:0]             instr_count
);

    localparam logic [31:0] WIN_LAST = RESET_PC + 32'(4 * MEM_WORDS) - 32'd4;
    localparam int          SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = 1;

    // A fetch target is legal when word aligned and inside the memory window.
    function automatic logic pc_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= RESET_PC) && (a <= WIN_LAST);
    endfunction

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic            live_p0;
    logic [31:0]     pc_p0;
    logic            epoch_p0;
    logic [SW-1:0]   starve;
    logic            fault_q;

    logic            vld_p1;
    logic            epoch_p1;
    logic [31:0]     pc_p1;
    logic            dbg_vld_p1;

    logic            q_valid;
    logic [63:0]     q_head;
    logic [1:0]      q_count;
    logic            q_push;

    logic            pop;
    logic [2:0]      occ;
    logic            credit;
    logic            fetch_want;
    logic            dbg_win;
    logic            issue;
    logic            fault_set;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next state, port arbitration and fetch issue decision.
    always_comb begin
        state_nxt  = state;
        fetch_want = 1'b0;
        dbg_win    = 1'b0;
        issue      = 1'b0;
        fault_set  = 1'b0;
        pop        = q_valid && bus.out_ready;
        occ        = 3'(q_count) + 3'(vld_p1);
        credit     = occ < (3'd2 + 3'(pop));
        case (state)
            ST_RUN: begin
                fetch_want = live_p0 && credit && !redirect_valid && !halt_req;
                dbg_win    = live_p0 && bus.dbg_req &&
                             (!fetch_want || (starve >= STARVE_LIM));
                if (fetch_want && !dbg_win) begin
                    if (pc_legal(pc_p0)) issue     = 1'b1;
                    else                 fault_set = 1'b1;
                end
                if (halt_req || fault_set) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                dbg_win = live_p0 && bus.dbg_req;
            end
            default: begin
                state_nxt = ST_HALTED;
            end
        endcase
    end

    // PC, epoch, start-up gate, starvation, fault and retirement counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_p0     <= 1'b0;
            pc_p0       <= RESET_PC;
            epoch_p0    <= 1'b0;
            starve      <= '0;
            fault_q     <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            live_p0 <= 1'b1;
            if (redirect_valid) begin
                pc_p0    <= redirect_pc;
                epoch_p0 <= ~epoch_p0;
            end else if (issue) begin
                pc_p0 <= pc_p0 + 32'd4;
            end
            if (dbg_win)
                starve <= '0;
            else if (bus.dbg_req && (starve < STARVE_LIM))
                starve <= starve + STARVE_ONE;
            if (fault_set) fault_q <= 1'b1;
            if (pop) instr_count <= instr_count + 32'd1;
        end
    end

    // ---- p0 -> p1: read issued, response returns next cycle ----
    // In-flight read tracking for fetch and debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            epoch_p1   <= 1'b0;
            dbg_vld_p1 <= 1'b0;
        end else begin
            vld_p1     <= issue;
            epoch_p1   <= epoch_p0;
            dbg_vld_p1 <= dbg_win;
        end
    end

    // Issued PC travels with the in-flight read.
    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= pc_p0;
    end

    // ---- p1 -> queue: response tagged with its PC, stale epochs dropped ----
    assign q_push = vld_p1 && (epoch_p1 == epoch_p0);

    imem_fetch_ctrl_fetch_queue2 #(
        .DATA_W (64)
    ) u_fetch_queue2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_data  ({bus.mem_rdata, pc_p1}),
        .pop        (pop),
        .head_valid (q_valid),
        .head_data  (q_head),
        .count      (q_count)
    );

    assign bus.mem_req    = issue || dbg_win;
    assign bus.mem_addr   = dbg_win ? word_addr(bus.dbg_addr) :
                            (issue  ? word_addr(pc_p0) : 30'd0);
    assign bus.dbg_gnt    = dbg_win;
    assign bus.dbg_rvalid = dbg_vld_p1;
    assign bus.dbg_rdata  = dbg_vld_p1 ? bus.mem_rdata : 32'd0;
    assign bus.out_valid  = q_valid;
    assign bus.out_instr  = q_valid ? q_head[63:32] : 32'd0;
    assign bus.out_pc     = q_valid ? q_head[31:0]  : 32'd0;
    assign fault          = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a memory model and a PC scoreboard.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam int          MW   = 256;
    localparam int          SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        fault;
    logic [31:0] instr_count;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(
        .RESET_PC   (RPC),
        .MEM_WORDS  (MW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .bus            (bus),
        .fault          (fault),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MW];
    logic [31:0] exp_q [$];
    logic [31:0] mon_pc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          hs_cnt  = 0;
    bit          seen;
    bit          got_gnt;

    // Memory model: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return mem[w[7:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_out(input string tag, input int maxc);
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        n_tests++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL %s: observed out_valid=0 for %0d cycles expected 1", tag, maxc);
        end
    endtask

    // Scoreboard: every handshake must match the next expected PC and word,
    // and instr_count must track the handshakes seen so far.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_cnt = 0;
        end else begin
            chk("instr_count", instr_count, 32'(hs_cnt));
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_out: observed pc %h expected no output", bus.out_pc);
                end
                if (exp_q.size() != 0) begin
                    mon_pc = exp_q.pop_front();
                    chk("out_pc", bus.out_pc, mon_pc);
                    chk("out_instr", bus.out_instr, exp_instr(mon_pc));
                end
                hs_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = {8'hA5, 8'(i), 16'(i * 977 + 32'h1234)};
        bus.out_ready = 1'b0;
        bus.dbg_req   = 1'b0;
        bus.dbg_addr  = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        chk("rst_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // Streaming from RESET_PC with decode always ready
        step(1);
        fill_exp(RPC, 64);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        wait_out("start", 6);
        chk("start_pc", bus.out_pc, RPC);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
        end

        // Backpressure: two words held, no further reads
        step(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("hold_mem_req", {31'd0, bus.mem_req}, 32'd0);
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_count", {30'd0, dut.u_fetch_queue2.count}, 32'd2);
            end
        end
        step(1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("release_valid", {31'd0, bus.out_valid}, 32'd1);
        end

        // Redirect while streaming (read in flight)
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = RPC + 32'h40;
        @(negedge clk);
        chk("redir_no_fetch", {31'd0, bus.mem_req}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
        fill_exp(RPC + 32'h40, 64);
        @(negedge clk);
        chk("redir_flush", {31'd0, bus.out_valid}, 32'd0);
        wait_out("redir1", 6);
        chk("redir1_pc", bus.out_pc, RPC + 32'h40);

        // Redirect with the queue full
        step(1);
        bus.out_ready = 1'b0;
        step(4);
        @(negedge clk);
        chk("full_count", {30'd0, dut.u_fetch_queue2.count}, 32'd2);
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = RPC + 32'h80;
        @(negedge clk);
        chk("redir2_no_fetch", {31'd0, bus.mem_req}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
        bus.out_ready  = 1'b1;
        fill_exp(RPC + 32'h80, 64);
        wait_out("redir2", 6);
        chk("redir2_pc", bus.out_pc, RPC + 32'h80);

        // Debug read against continuous fetch
        step(1);
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = RPC + 32'd800;
        got_gnt = 1'b0;
        for (int i = 0; i < SMAX + 1 && !got_gnt; i++) begin
            @(negedge clk);
            if (bus.dbg_gnt) begin
                got_gnt = 1'b1;
                chk("dbg_mem_req", {31'd0, bus.mem_req}, 32'd1);
                chk("dbg_mem_addr", {2'b00, bus.mem_addr}, (RPC + 32'd800) >> 2);
            end
        end
        n_tests++;
        assert (got_gnt) else begin
            n_fail++;
            $error("FAIL dbg_gnt_latency: observed no grant expected within %0d cycles", SMAX + 1);
        end
        step(1);
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
        chk("dbg_rdata", bus.dbg_rdata, mem[200]);

        // Misaligned redirect target faults and halts fetching
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = RPC + 32'h42;
        @(negedge clk);
        step(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fault_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk("fault_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("fault_flag", {31'd0, fault}, 32'd1);

        // Debug is granted at once while halted
        step(1);
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = RPC + 32'd68;
        @(negedge clk);
        chk("halted_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        step(1);
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("halted_dbg_rdata", bus.dbg_rdata, mem[17]);

        // Asynchronous reset clears the sticky fault
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_fault_clr", {31'd0, fault}, 32'd0);
        step(2);
        fill_exp(RPC, 64);
        rst_n = 1'b1;
        wait_out("restart1", 6);
        chk("restart1_pc", bus.out_pc, RPC);

        // Halt: fetching stops, queue drains
        step(3);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_mem_req", {31'd0, bus.mem_req}, 32'd0);
            if (i >= 2) chk("halt_drained", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("halt_no_fault", {31'd0, fault}, 32'd0);

        // Reset in the middle of a debug read
        step(1);
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = RPC + 32'd20;
        @(negedge clk);
        chk("midread_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        step(1);
        bus.dbg_req = 1'b0;
        chk("midread_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        chk("async_dbg_rdata", bus.dbg_rdata, 32'd0);
        chk("async_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_count", instr_count, 32'd0);
        step(2);
        fill_exp(RPC, 16);
        rst_n = 1'b1;
        wait_out("restart2", 6);
        chk("restart2_pc", bus.out_pc, RPC);
        step(3);
        bus.out_ready = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
